// File: rtl/tetris_pkg.sv
// Shared types and constants for the piece dispenser and its bag generator.
package tetris_pkg;
  localparam int BAG_SIZE = 7;
  localparam int PIECE_W  = 3;

  typedef logic [PIECE_W-1:0] piece_t;

  localparam piece_t PIECE_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {F_IDLE, F_ARM, F_WAIT} fill_state_t;
endpackage

// File: rtl/piece_dispenser.sv
// Double-buffered bag dispenser: pops pieces from cur, refills cur/nxt from
// the bag generator through a request/ready handshake.
module piece_dispenser #(
  parameter int BAG_SIZE = tetris_pkg::BAG_SIZE,
  parameter int PIECE_W  = tetris_pkg::PIECE_W
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        newbag,
  input  logic                        ready,
  input  logic [BAG_SIZE*PIECE_W-1:0] pieces,
  input  logic                        piece_req,
  output logic [PIECE_W-1:0]          piece,
  output logic                        piece_valid,
  output logic [PIECE_W-1:0]          preview,
  output logic                        preview_valid,
  output logic                        bag_error
);
  import tetris_pkg::*;

  localparam int BAG_W = BAG_SIZE * PIECE_W;
  localparam int IDX_W = (BAG_SIZE > 1) ? $clog2(BAG_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BAG_SIZE - 1);

  fill_state_t      state_q, state_d;
  logic [BAG_W-1:0] cur_q, cur_d, nxt_q, nxt_d;
  logic [IDX_W-1:0] idx_q, idx_d, pv_idx;
  logic             cur_vld_q, cur_vld_d, nxt_vld_q, nxt_vld_d;
  logic             err_q, err_d;
  logic             pop, at_last, capture, bag_bad;

  assign pop     = piece_req && cur_vld_q;
  assign at_last = (idx_q == LAST);
  assign capture = (state_q == F_WAIT) && ready;

  always_comb begin
    state_d = state_q;
    newbag  = 1'b0;
    case (state_q)
      F_IDLE: if (!cur_vld_q || !nxt_vld_q) state_d = F_ARM;
      // A ready left high from the previous bag must drop before we trust it.
      F_ARM: begin
        newbag = 1'b1;
        if (!ready) state_d = F_WAIT;
      end
      F_WAIT: begin
        newbag = 1'b1;
        if (ready) state_d = F_IDLE;
      end
      default: state_d = F_IDLE;
    endcase
  end

  always_comb begin
    bag_bad = 1'b0;
    for (int k = 0; k < BAG_SIZE; k++)
      if (pieces[k*PIECE_W +: PIECE_W] == PIECE_W'(PIECE_ILLEGAL)) bag_bad = 1'b1;
  end

  always_comb begin
    cur_d     = cur_q;
    nxt_d     = nxt_q;
    idx_d     = idx_q;
    cur_vld_d = cur_vld_q;
    nxt_vld_d = nxt_vld_q;
    err_d     = err_q | (capture & bag_bad);
    if (pop) begin
      if (!at_last) begin
        idx_d = idx_q + 1'b1;
      end else if (nxt_vld_q) begin
        cur_d     = nxt_q;
        idx_d     = '0;
        nxt_vld_d = 1'b0;
      end else begin
        cur_vld_d = 1'b0;
      end
    end
    // cur_vld_d already reflects this cycle's pop, so a capture that meets a
    // draining cur lands straight in cur with no empty cycle.
    if (capture) begin
      if (!cur_vld_d) begin
        cur_d     = pieces;
        idx_d     = '0;
        cur_vld_d = 1'b1;
      end else begin
        nxt_d     = pieces;
        nxt_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= F_IDLE;
      cur_q     <= '0;
      nxt_q     <= '0;
      idx_q     <= '0;
      cur_vld_q <= 1'b0;
      nxt_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      nxt_q     <= nxt_d;
      idx_q     <= idx_d;
      cur_vld_q <= cur_vld_d;
      nxt_vld_q <= nxt_vld_d;
      err_q     <= err_d;
    end
  end

  assign pv_idx        = at_last ? '0 : idx_q + 1'b1;
  assign piece         = cur_q[PIECE_W*idx_q +: PIECE_W];
  assign piece_valid   = cur_vld_q;
  assign preview       = at_last ? nxt_q[PIECE_W-1:0] : cur_q[PIECE_W*pv_idx +: PIECE_W];
  assign preview_valid = cur_vld_q && (!at_last || nxt_vld_q);
  assign bag_error     = err_q;
endmodule

// File: tb/tb_piece_dispenser.sv
// Scoreboard bench: a behavioural bag generator feeds the dispenser and every
// captured piece is queued; pops and previews are compared against the queue.
module tb_piece_dispenser;
  localparam int BS = 7;
  localparam int PW = 3;
  localparam logic [BS*PW-1:0] FIRST_BAG = 21'h1AC688;
  localparam logic [BS*PW-1:0] STALE_BAG = {BS{3'd5}};

  logic             clk = 1'b0;
  logic             reset;
  logic             newbag, ready, piece_req;
  logic [BS*PW-1:0] pieces;
  logic [PW-1:0]    piece, preview;
  logic             piece_valid, preview_valid, bag_error;

  piece_dispenser #(.BAG_SIZE(BS), .PIECE_W(PW)) dut (
    .clk(clk), .reset(reset), .newbag(newbag), .ready(ready), .pieces(pieces),
    .piece_req(piece_req), .piece(piece), .piece_valid(piece_valid),
    .preview(preview), .preview_valid(preview_valid), .bag_error(bag_error)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_err = 0;
  logic [PW-1:0] exp_q[$];
  logic        err_exp = 1'b0;
  int          gph = 0, stale_cnt = 3, max_stale = 4, pop_pct = 0, bag_cnt = 0;
  logic        inject_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BS*PW-1:0] make_bag();
    logic [BS*PW-1:0] b;
    if (bag_cnt == 0) return FIRST_BAG;
    for (int k = 0; k < BS; k++) b[k*PW +: PW] = PW'($urandom_range(0, 6));
    if (inject_err) begin
      b[3*PW +: PW] = 3'd7;
      inject_err = 1'b0;
    end
    return b;
  endfunction

  // One cycle: generator reacts first, then the consumer checks and pops.
  task automatic step();
    @(negedge clk);
    case (gph)
      0: if (newbag) begin
        if (stale_cnt == 0) begin ready = 1'b0; gph = 1; end
        else stale_cnt--;
      end
      1: begin
        chk("newbag_hold", newbag, 1'b1);
        pieces = make_bag();
        ready  = 1'b1;
        gph    = 2;
      end
      default: if (!newbag) begin
        for (int k = 0; k < BS; k++) begin
          exp_q.push_back(pieces[k*PW +: PW]);
          if (pieces[k*PW +: PW] == 3'd7) err_exp = 1'b1;
        end
        bag_cnt++;
        pieces    = STALE_BAG;
        gph       = 0;
        stale_cnt = $urandom_range(0, max_stale);
      end
    endcase
    chk("piece_valid", piece_valid, exp_q.size() > 0);
    chk("preview_valid", preview_valid, exp_q.size() > 1);
    if (piece_valid && exp_q.size() > 0) chk("piece", piece, exp_q[0]);
    if (preview_valid && exp_q.size() > 1) chk("preview", preview, exp_q[1]);
    chk("bag_error", bag_error, err_exp);
    piece_req = ($urandom_range(0, 99) < pop_pct);
    if (piece_req && piece_valid && exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_newbag"}, newbag, 1'b0);
    chk({tag, "_piece"}, piece, 3'd0);
    chk({tag, "_piece_valid"}, piece_valid, 1'b0);
    chk({tag, "_preview"}, preview, 3'd0);
    chk({tag, "_preview_valid"}, preview_valid, 1'b0);
    chk({tag, "_bag_error"}, bag_error, 1'b0);
  endtask

  initial begin
    logic seen;
    // ready already high with a stale bag before newbag ever rises
    reset = 1'b1; ready = 1'b1; pieces = STALE_BAG; piece_req = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_reset_outputs("reset");
    @(negedge clk) reset = 1'b0;

    // fill both bags without popping
    pop_pct = 0;
    repeat (40) step();
    chk("first_piece", piece, 3'd0);
    chk("first_preview", preview, 3'd1);
    chk("two_bags_loaded", exp_q.size(), 14);

    // back-to-back pops across the bag boundary
    pop_pct = 100;
    repeat (12) step();

    // mixed rates and generator delays to hit boundary/capture collisions
    for (int r = 0; r < 6; r++) begin
      pop_pct   = (r % 2) ? 100 : 30 + 10 * r;
      max_stale = r * 2;
      repeat (500) step();
    end

    // a bag carrying an illegal code
    pop_pct = 60; inject_err = 1'b1;
    repeat (150) step();
    chk("err_seen", err_exp, 1'b1);

    // reset while the FSM waits for ready
    pop_pct = 100;
    begin
      int i;
      for (i = 0; i < 300 && gph != 1; i++) step();
      chk("reach_wait", gph, 1);
    end
    @(posedge clk); #1;
    reset = 1'b1; piece_req = 1'b0;
    #1 chk_reset_outputs("midfill_reset");
    exp_q.delete(); err_exp = 1'b0; gph = 0; ready = 1'b0; stale_cnt = 1;
    @(negedge clk) reset = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (newbag) seen = 1'b1;
    end
    chk("newbag_after_reset", seen, 1'b1);
    pop_pct = 50; max_stale = 3;
    repeat (400) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
